// File: rtl/dsm_cfg_serializer.sv
// dsm_cfg_serializer
// Parallel-to-serial transmitter for the DSM configuration link. Words are
// taken over a valid/ready handshake into a single holding register and
// shifted out MSB first as an ser_en/ser_data pair, with an optional idle
// gap after each frame. frame_done pulses in the cycle in which the DSM's
// serial-to-parallel register holds the complete word.
//
// Handshake: a word transfers on a rising sclk edge where tx_valid_i and
// tx_ready_o are both 1. tx_ready_o depends only on the holding register
// (never on tx_valid_i), tx_data_i is ignored whenever tx_ready_o is 0, and
// the source may change tx_data_i freely while it is not being accepted.

module dsm_cfg_serializer #(
  parameter int WIDTH      = 9,
  parameter int GAP_CYCLES = 1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             ser_en_o,
  output logic             ser_data_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bit counter wide enough to hold WIDTH-1.
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  // Gap counter value on the last idle cycle; unused when there is no gap.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             frame_done_q, frame_done_d;

  // Event decode shared by the next-state and datapath logic.
  logic accept;
  logic last_bit;
  logic gap_end;
  logic load;

  // Decode accept, last-bit, gap-end and load events from the current registers.
  always_comb begin
    accept   = tx_valid_i && !hold_v_q;
    last_bit = (state_q == ST_SHIFT) && (bcnt_q == BIT_LAST);
    gap_end  = (state_q == ST_GAP) && (gcnt_q == GAP_LAST);
    // A queued word is loaded from IDLE, at the end of a gap, or directly
    // at the last bit when frames run back-to-back with no gap.
    load     = hold_v_q && ((state_q == ST_IDLE) ||
                            (last_bit && !HAS_GAP) ||
                            gap_end);
  end

  // State register.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (HAS_GAP) begin
            state_d = ST_GAP;
          end else if (load) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          state_d = load ? ST_SHIFT : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for the holding register, shift register and counters.
  always_comb begin
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
    sh_d         = sh_q;
    bcnt_d       = bcnt_q;
    gcnt_d       = gcnt_q;
    frame_done_d = last_bit;

    // Accept and load are mutually exclusive: accept needs hold_v_q = 0,
    // load needs hold_v_q = 1.
    if (accept) begin
      hold_d   = tx_data_i;
      hold_v_d = 1'b1;
    end else if (load) begin
      hold_v_d = 1'b0;
    end

    if (load) begin
      sh_d   = hold_q;
      bcnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      sh_d   = {sh_q[WIDTH-2:0], 1'b0};
      bcnt_d = bcnt_q + 1'b1;
    end

    if (last_bit) begin
      gcnt_d = 4'd0;
    end else if (state_q == ST_GAP) begin
      gcnt_d = gcnt_q + 4'd1;
    end
  end

  // Datapath registers; a reset mid-frame discards the partial frame.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      sh_q         <= '0;
      bcnt_q       <= '0;
      gcnt_q       <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      sh_q         <= sh_d;
      bcnt_q       <= bcnt_d;
      gcnt_q       <= gcnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs decode directly from registers only.
  always_comb begin
    tx_ready_o   = !hold_v_q;
    ser_en_o     = (state_q == ST_SHIFT);
    ser_data_o   = sh_q[WIDTH-1] & (state_q == ST_SHIFT);
    frame_done_o = frame_done_q;
    busy_o       = (state_q != ST_IDLE) | hold_v_q;
    state_o      = state_q;
  end

endmodule

// File: tb/tb_dsm_cfg_serializer.sv
// Bench for dsm_cfg_serializer: four instances (WIDTH/GAP = 9/1, 9/0, 9/3,
// 2/0). Drivers push every accepted word onto a per-instance expected queue;
// a monitor models the DSM receiver shift register and pops/compares at each
// frame_done pulse, also tracking ser_en run lengths, gaps and frame period.

module tb_dsm_cfg_serializer;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  // Clock and reset block.
  always #5 sclk = ~sclk;

  logic [3:0][31:0] tx_data;
  logic [3:0]       tx_valid;
  wire  [3:0]       tx_ready, ser_en, ser_data, frame_done, busy;
  wire  [1:0]       st0, st1, st2, st3;

  dsm_cfg_serializer #(.WIDTH(9), .GAP_CYCLES(1)) u_w9g1 (
    .sclk(sclk), .rst(rst), .tx_data_i(tx_data[0][8:0]), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(tx_ready[0]), .ser_en_o(ser_en[0]), .ser_data_o(ser_data[0]),
    .frame_done_o(frame_done[0]), .busy_o(busy[0]), .state_o(st0));

  dsm_cfg_serializer #(.WIDTH(9), .GAP_CYCLES(0)) u_w9g0 (
    .sclk(sclk), .rst(rst), .tx_data_i(tx_data[1][8:0]), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(tx_ready[1]), .ser_en_o(ser_en[1]), .ser_data_o(ser_data[1]),
    .frame_done_o(frame_done[1]), .busy_o(busy[1]), .state_o(st1));

  dsm_cfg_serializer #(.WIDTH(9), .GAP_CYCLES(3)) u_w9g3 (
    .sclk(sclk), .rst(rst), .tx_data_i(tx_data[2][8:0]), .tx_valid_i(tx_valid[2]),
    .tx_ready_o(tx_ready[2]), .ser_en_o(ser_en[2]), .ser_data_o(ser_data[2]),
    .frame_done_o(frame_done[2]), .busy_o(busy[2]), .state_o(st2));

  dsm_cfg_serializer #(.WIDTH(2), .GAP_CYCLES(0)) u_w2g0 (
    .sclk(sclk), .rst(rst), .tx_data_i(tx_data[3][1:0]), .tx_valid_i(tx_valid[3]),
    .tx_ready_o(tx_ready[3]), .ser_en_o(ser_en[3]), .ser_data_o(ser_data[3]),
    .frame_done_o(frame_done[3]), .busy_o(busy[3]), .state_o(st3));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] exp_q [4][$];
  logic        bitlog[4][$];
  logic [31:0] rx[4];
  int bits[4], fd_cnt[4], en_run[4], max_run[4], idle_run[4];
  int last_gap[4], prev_fd[4], last_period[4];

  function automatic int wid(input int i);
    return (i == 3) ? 2 : 9;
  endfunction

  function automatic logic [31:0] msk(input int i);
    return (32'h1 << wid(i)) - 32'h1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: receiver model plus scoreboard pop at every frame_done pulse.
  always @(negedge sclk) begin
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        rx[i] = '0; bits[i] = 0; en_run[i] = 0; idle_run[i] = 0;
      end else begin
        if (frame_done[i]) begin
          fd_cnt[i]++;
          if (prev_fd[i] > 0) last_period[i] = cyc - prev_fd[i];
          prev_fd[i] = cyc;
          chk($sformatf("frame_bits[%0d]", i), 32'(bits[i]), 32'(wid(i)));
          if (exp_q[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame[%0d]: got %0h expected no frame", i, rx[i] & msk(i));
          end else begin
            chk($sformatf("frame_word[%0d]", i), rx[i] & msk(i), exp_q[i].pop_front());
          end
          rx[i] = '0; bits[i] = 0;
        end
        if (ser_en[i]) begin
          if (idle_run[i] > 0 && fd_cnt[i] > 0) last_gap[i] = idle_run[i];
          idle_run[i] = 0;
          rx[i] = {rx[i][30:0], ser_data[i]};
          bits[i]++;
          en_run[i]++;
          if (en_run[i] > max_run[i]) max_run[i] = en_run[i];
          bitlog[i].push_back(ser_data[i]);
        end else begin
          en_run[i] = 0;
          idle_run[i]++;
          chk($sformatf("data_when_idle[%0d]", i), 32'(ser_data[i]), 32'd0);
        end
      end
    end
  end

  // Driver: offer one word and hold it until accepted (called at a negedge).
  task automatic send(input int i, input logic [31:0] d);
    int n;
    n = 0;
    tx_data[i]  = d & msk(i);
    tx_valid[i] = 1'b1;
    while (!tx_ready[i] && n < 300) begin
      @(negedge sclk);
      n++;
    end
    if (!tx_ready[i]) begin
      checks++; errors++;
      $display("FAIL send_timeout[%0d]: got ready=0 expected ready=1", i);
    end else begin
      @(posedge sclk);
      exp_q[i].push_back(d & msk(i));
      @(negedge sclk);
    end
    tx_valid[i] = 1'b0;
  endtask

  // Driver: random words, random idle spacing, data churns while not ready.
  task automatic stream(input int i, input int n, input int idle_max);
    int t;
    bit done;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, idle_max)) begin
        tx_valid[i] = 1'b0;
        tx_data[i]  = $urandom & msk(i);
        @(negedge sclk);
      end
      tx_valid[i] = 1'b1;
      done = 1'b0;
      t = 0;
      while (!done && t < 300) begin
        tx_data[i] = $urandom & msk(i);
        if (tx_ready[i]) begin
          @(posedge sclk);
          exp_q[i].push_back(tx_data[i]);
          done = 1'b1;
        end
        @(negedge sclk);
        t++;
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL stream_timeout[%0d]: got no accept expected accept", i);
      end
    end
    tx_valid[i] = 1'b0;
  endtask

  // Wait until the instance is idle and its scoreboard has drained.
  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(negedge sclk);
      #1;
      n++;
    end while ((busy[i] || exp_q[i].size() != 0) && n < 600);
    chk($sformatf("drained[%0d]", i), {31'd0, busy[i] | (exp_q[i].size() != 0)}, 32'd0);
    repeat (2) @(negedge sclk);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] v;
    bit ok;
    int fd0;

    tx_data  = '0;
    tx_valid = '0;
    for (int i = 0; i < 4; i++) begin
      rx[i] = '0; bits[i] = 0; fd_cnt[i] = 0; en_run[i] = 0; max_run[i] = 0;
      idle_run[i] = 0; last_gap[i] = 0; prev_fd[i] = 0; last_period[i] = 0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    chk("rst_tx_ready",   32'(tx_ready),   32'hF);
    chk("rst_ser_en",     32'(ser_en),     32'h0);
    chk("rst_ser_data",   32'(ser_data),   32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_state_idle", 32'({st3, st2, st1, st0}), 32'h0);
    #2 rst = 1'b0;
    @(negedge sclk);

    // Single word 9'h1A5 from IDLE, GAP_CYCLES=1.
    tx_data[0]  = 32'h1A5;
    tx_valid[0] = 1'b1;
    @(posedge sclk);
    exp_q[0].push_back(32'h1A5);
    @(negedge sclk);
    tx_valid[0] = 1'b0;
    chk("t1_en_not_yet",     32'(ser_en[0]),   32'd0);
    chk("t1_ready_low_held", 32'(tx_ready[0]), 32'd0);
    chk("t1_busy_held",      32'(busy[0]),     32'd1);
    @(negedge sclk);
    chk("t1_en_start",       32'(ser_en[0]),   32'd1);
    chk("t1_ready_after_ld", 32'(tx_ready[0]), 32'd1);
    ok = 1'b1;
    word = '0;
    for (int k = 0; k < 9; k++) begin
      word = {word[30:0], ser_data[0]};
      if (!ser_en[0]) ok = 1'b0;
      @(negedge sclk);
    end
    chk("t1_en_9_cycles",  32'(ok),            32'd1);
    chk("t1_serial_bits",  word,               32'h1A5);
    chk("t1_frame_done",   32'(frame_done[0]), 32'd1);
    chk("t1_en_dropped",   32'(ser_en[0]),     32'd0);
    @(negedge sclk);
    chk("t1_done_is_pulse", 32'(frame_done[0]), 32'd0);
    wait_idle(0);
    chk("t1_one_frame", 32'(fd_cnt[0]), 32'd1);

    // Three queued words, GAP_CYCLES=0: one continuous 27-cycle burst.
    max_run[1] = 0;
    fd0 = fd_cnt[1];
    send(1, 32'h1A5);
    send(1, 32'h0FF);
    send(1, 32'h100);
    wait_idle(1);
    chk("t2_continuous_en", 32'(max_run[1]), 32'd27);
    chk("t2_three_frames",  32'(fd_cnt[1] - fd0), 32'd3);

    // GAP_CYCLES=3: three idle cycles between frames, 12-cycle period.
    send(2, $urandom & 32'h1FF);
    send(2, $urandom & 32'h1FF);
    wait_idle(2);
    chk("t3_gap_len", 32'(last_gap[2]),    32'd3);
    chk("t3_period",  32'(last_period[2]), 32'd12);

    // Reset mid-frame (after the 4th bit) with a second word queued.
    send(0, 32'h1A5);
    send(0, 32'h055);
    repeat (3) @(negedge sclk);
    chk("t4_busy_before",  32'(busy[0]),     32'd1);
    chk("t4_queued",       32'(tx_ready[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_ser_en",     32'(ser_en[0]),     32'd0);
    chk("t4_rst_ser_data",   32'(ser_data[0]),   32'd0);
    chk("t4_rst_busy",       32'(busy[0]),       32'd0);
    chk("t4_rst_frame_done", 32'(frame_done[0]), 32'd0);
    chk("t4_rst_tx_ready",   32'(tx_ready[0]),   32'd1);
    exp_q[0].delete();
    @(negedge sclk);
    #2 rst = 1'b0;
    @(negedge sclk);
    ok = 1'b1;
    repeat (20) begin
      if (ser_en[0] || busy[0] || frame_done[0]) ok = 1'b0;
      @(negedge sclk);
    end
    chk("t4_silent_after_rst", 32'(ok), 32'd1);
    send(0, 32'h0AA);
    wait_idle(0);

    // WIDTH=2 corner: 2'b10 then 2'b01 back-to-back.
    bitlog[3].delete();
    max_run[3] = 0;
    send(3, 32'h2);
    send(3, 32'h1);
    wait_idle(3);
    chk("t5_en_run", 32'(max_run[3]), 32'd4);
    chk("t5_bit_count", 32'(bitlog[3].size()), 32'd4);
    v = '0;
    for (int k = 0; k < bitlog[3].size(); k++) v = {v[30:0], bitlog[3][k]};
    chk("t5_bit_seq", v, 32'h9);

    // Randomized streams on every instance, spaced and back-to-back.
    for (int i = 0; i < 4; i++) begin
      stream(i, 25, 3);
      wait_idle(i);
      stream(i, 12, 0);
      wait_idle(i);
    end

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("final_queue_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time bound expired");
  end

endmodule
